freg_wrarb: RTL and testbench

- Write-port arbiter and pending-write scoreboard for the FPU's 3R1W register file.
- Three result sources compete for the single write port: load data, FMA pipeline and divide/sqrt unit. Each uses a valid/ready handshake.
- The block grants one source per cycle and registers the winner onto the write port.
- Keeps a 32-bit busy bitmap so issue logic can stall on RAW/WAW hazards.

---
 rtl/freg_wrarb.sv | 128 ++++++++++++
 tb/tb_freg_wrarb.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/freg_wrarb.sv
// Write-port arbiter and pending-write scoreboard for the FPU's 3R1W register file.
// Optional same-cycle forwarding of the registered write is enabled by FREG_WRARB_FWD_EN.
module freg_wrarb #(
  parameter int FLEN      = 64,
  parameter int AGE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ld_valid,
  input  logic [4:0]      ld_addr,
  input  logic [FLEN-1:0] ld_data,
  output logic            ld_ready,
  input  logic            fma_valid,
  input  logic [4:0]      fma_addr,
  input  logic [FLEN-1:0] fma_data,
  output logic            fma_ready,
  input  logic            div_valid,
  input  logic [4:0]      div_addr,
  input  logic [FLEN-1:0] div_data,
  output logic            div_ready,
  input  logic            issue_valid,
  input  logic [4:0]      issue_rd,
  output logic            rf_we,
  output logic [4:0]      rf_wa,
  output logic [FLEN-1:0] rf_wd,
  output logic [31:0]     busy,
  output logic            fwd_valid,
  output logic [4:0]      fwd_addr,
  output logic [FLEN-1:0] fwd_data
);

  localparam logic [3:0] AGE_MAX = 4'(AGE_LIMIT);

  logic [3:0]      ld_age, fma_age, div_age;
  logic            ld_urg, fma_urg, div_urg;
  logic            transfer;
  logic [4:0]      win_addr;
  logic [FLEN-1:0] win_data;
  logic [31:0]     busy_q, set_mask, clr_mask;

  assign ld_urg  = ld_valid  && (ld_age  == AGE_MAX);
  assign fma_urg = fma_valid && (fma_age == AGE_MAX);
  assign div_urg = div_valid && (div_age == AGE_MAX);

  // Urgent requesters reverse the base order so the slowest unit drains first.
  always_comb begin
    ld_ready  = 1'b0;
    fma_ready = 1'b0;
    div_ready = 1'b0;
    if (ld_urg || fma_urg || div_urg) begin
      if (div_urg)      div_ready = 1'b1;
      else if (fma_urg) fma_ready = 1'b1;
      else              ld_ready  = 1'b1;
    end else if (ld_valid)  ld_ready  = 1'b1;
    else if (fma_valid)     fma_ready = 1'b1;
    else if (div_valid)     div_ready = 1'b1;
  end

  assign transfer = ld_ready || fma_ready || div_ready;

  always_comb begin
    win_addr = ld_addr;
    win_data = ld_data;
    if (fma_ready) begin
      win_addr = fma_addr;
      win_data = fma_data;
    end else if (div_ready) begin
      win_addr = div_addr;
      win_data = div_data;
    end
  end

  function automatic logic [3:0] next_age(input logic valid, input logic granted,
                                          input logic [3:0] age);
    if (!valid || granted) return 4'd0;
    if (age == AGE_MAX)    return age;
    return age + 4'd1;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ld_age  <= 4'd0;
      fma_age <= 4'd0;
      div_age <= 4'd0;
    end else begin
      ld_age  <= next_age(ld_valid,  ld_ready,  ld_age);
      fma_age <= next_age(fma_valid, fma_ready, fma_age);
      div_age <= next_age(div_valid, div_ready, div_age);
    end
  end

  // Address and data hold their last values when no write happens.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rf_we <= 1'b0;
      rf_wa <= 5'd0;
      rf_wd <= '0;
    end else begin
      rf_we <= transfer;
      if (transfer) begin
        rf_wa <= win_addr;
        rf_wd <= win_data;
      end
    end
  end

  assign set_mask = issue_valid ? (32'd1 << issue_rd) : 32'd0;
  assign clr_mask = rf_we ? (32'd1 << rf_wa) : 32'd0;

  // A new issue to the register being written keeps it pending.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) busy_q <= 32'd0;
    else       busy_q <= (busy_q & ~clr_mask) | set_mask;
  end

`ifdef FREG_WRARB_FWD_EN
  assign fwd_valid = rf_we;
  assign fwd_addr  = rf_wa;
  assign fwd_data  = rf_wd;
  assign busy      = busy_q & ~(clr_mask & ~set_mask);
`else
  assign fwd_valid = 1'b0;
  assign fwd_addr  = 5'd0;
  assign fwd_data  = '0;
  assign busy      = busy_q;
`endif

endmodule

// File: tb/tb_freg_wrarb.sv
// Directed bench for freg_wrarb: grant table, contention, ageing, scoreboard, reset.
// Forwarding expectations follow FREG_WRARB_FWD_EN.
module tb_freg_wrarb;
  localparam int FLEN = 64;
`ifdef FREG_WRARB_FWD_EN
  localparam logic FWD = 1'b1;
`else
  localparam logic FWD = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic ld_valid, fma_valid, div_valid, issue_valid;
  logic [4:0] ld_addr, fma_addr, div_addr, issue_rd;
  logic [FLEN-1:0] ld_data, fma_data, div_data;
  logic ld_ready, fma_ready, div_ready;
  logic rf_we, fwd_valid;
  logic [4:0] rf_wa, fwd_addr;
  logic [FLEN-1:0] rf_wd, fwd_data;
  logic [31:0] busy;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic lv, fv, dv;
    logic [2:0] rdy;
    logic we;
    logic [4:0] wa;
    logic [63:0] wd;
  } vec_t;
  vec_t vecs[9];

  freg_wrarb #(.FLEN(FLEN), .AGE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data), .ld_ready(ld_ready),
    .fma_valid(fma_valid), .fma_addr(fma_addr), .fma_data(fma_data), .fma_ready(fma_ready),
    .div_valid(div_valid), .div_addr(div_addr), .div_data(div_data), .div_ready(div_ready),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd), .busy(busy),
    .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    ld_valid  = v.lv; ld_addr  = 5'd1; ld_data  = 64'h1111;
    fma_valid = v.fv; fma_addr = 5'd2; fma_data = 64'h2222;
    div_valid = v.dv; div_addr = 5'd3; div_data = 64'h3333;
  endtask

  task automatic idle();
    ld_valid = 1'b0; fma_valid = 1'b0; div_valid = 1'b0; issue_valid = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] readies();
    return {ld_ready, fma_ready, div_ready};
  endfunction

  initial begin
    logic [2:0] starve[10];
    vecs[0] = '{1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 5'd0, 64'h0};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 3'b001, 1'b1, 5'd3, 64'h3333};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 3'b010, 1'b1, 5'd2, 64'h2222};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 3'b010, 1'b1, 5'd2, 64'h2222};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 3'b100, 1'b1, 5'd1, 64'h1111};
    vecs[5] = '{1'b1, 1'b0, 1'b1, 3'b100, 1'b1, 5'd1, 64'h1111};
    vecs[6] = '{1'b1, 1'b1, 1'b0, 3'b100, 1'b1, 5'd1, 64'h1111};
    vecs[7] = '{1'b1, 1'b1, 1'b1, 3'b100, 1'b1, 5'd1, 64'h1111};
    vecs[8] = '{1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 5'd1, 64'h1111};
    starve = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b001,
               3'b010, 3'b100, 3'b100, 3'b100, 3'b001};

    reset = 1'b1;
    idle();
    ld_addr = 5'd0; fma_addr = 5'd0; div_addr = 5'd0; issue_rd = 5'd0;
    ld_data = '0; fma_data = '0; div_data = '0;
    #12;
    checkOutput("reset rf_we", 64'(rf_we), 64'd0);
    checkOutput("reset rf_wa", 64'(rf_wa), 64'd0);
    checkOutput("reset rf_wd", rf_wd, 64'd0);
    checkOutput("reset busy", 64'(busy), 64'd0);
    checkOutput("reset fwd_valid", 64'(fwd_valid), 64'd0);
    reset = 1'b0;
    step();

    // Grant table, each vector from idle (ages cleared).
    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i]);
      #1;
      checkOutput($sformatf("vec%0d ready", i), 64'(readies()), 64'(vecs[i].rdy));
      step();
      checkOutput($sformatf("vec%0d rf_we", i), 64'(rf_we), 64'(vecs[i].we));
      checkOutput($sformatf("vec%0d rf_wa", i), 64'(rf_wa), 64'(vecs[i].wa));
      checkOutput($sformatf("vec%0d rf_wd", i), rf_wd, vecs[i].wd);
      idle();
      step();
    end

    // Single load.
    ld_valid = 1'b1; ld_addr = 5'd5; ld_data = 64'h3FF0000000000000;
    #1;
    checkOutput("single ready", 64'(readies()), 64'b100);
    step();
    idle();
    checkOutput("single rf_we", 64'(rf_we), 64'd1);
    checkOutput("single rf_wa", 64'(rf_wa), 64'd5);
    checkOutput("single rf_wd", rf_wd, 64'h3FF0000000000000);
    step();

    // Three-way contention drained in grant order.
    ld_valid = 1'b1; ld_addr = 5'd10;
    fma_valid = 1'b1; fma_addr = 5'd11;
    div_valid = 1'b1; div_addr = 5'd12;
    #1;
    checkOutput("cont c0 ready", 64'(readies()), 64'b100);
    step();
    ld_valid = 1'b0;
    #1;
    checkOutput("cont c1 ready", 64'(readies()), 64'b010);
    checkOutput("cont c1 rf_wa", 64'(rf_wa), 64'd10);
    step();
    fma_valid = 1'b0;
    #1;
    checkOutput("cont c2 ready", 64'(readies()), 64'b001);
    checkOutput("cont c2 rf_wa", 64'(rf_wa), 64'd11);
    step();
    idle();
    checkOutput("cont c3 rf_wa", 64'(rf_wa), 64'd12);
    checkOutput("cont c3 rf_we", 64'(rf_we), 64'd1);
    step();

    // Starvation with AGE_LIMIT=4, ten bounded cycles.
    ld_valid = 1'b1; fma_valid = 1'b1; div_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      #1;
      checkOutput($sformatf("starve c%0d ready", c), 64'(readies()), 64'(starve[c]));
      step();
    end
    idle();
    step();

    // Scoreboard set / clear / collision.
    issue_valid = 1'b1; issue_rd = 5'd12;
    step();
    issue_valid = 1'b0;
    checkOutput("sb set busy", 64'(busy), 64'h1000);
    fma_valid = 1'b1; fma_addr = 5'd12; fma_data = 64'h55;
    #1;
    checkOutput("sb fma ready", 64'(readies()), 64'b010);
    step();
    fma_valid = 1'b0;
    checkOutput("sb write cycle busy", 64'(busy[12]), 64'(!FWD));
    step();
    checkOutput("sb cleared busy", 64'(busy), 64'h0);
    issue_valid = 1'b1;
    step();
    issue_valid = 1'b0;
    fma_valid = 1'b1;
    step();
    fma_valid = 1'b0;
    issue_valid = 1'b1; issue_rd = 5'd12;
    #1;
    checkOutput("sb collide rf_wa", 64'(rf_wa), 64'd12);
    checkOutput("sb collide busy now", 64'(busy[12]), 64'd1);
    step();
    issue_valid = 1'b0;
    checkOutput("sb collide busy after", 64'(busy), 64'h1000);
    checkOutput("sb collide rf_we", 64'(rf_we), 64'd0);
    step();

    // Write to reg 7 and the forward path.
    issue_valid = 1'b1; issue_rd = 5'd7;
    step();
    issue_valid = 1'b0;
    div_valid = 1'b1; div_addr = 5'd7; div_data = 64'hABCD;
    step();
    div_valid = 1'b0;
    checkOutput("fwd rf_wd", rf_wd, 64'hABCD);
    checkOutput("fwd valid", 64'(fwd_valid), 64'(FWD));
    checkOutput("fwd addr", 64'(fwd_addr), FWD ? 64'd7 : 64'd0);
    checkOutput("fwd data", fwd_data, FWD ? 64'hABCD : 64'd0);
    checkOutput("fwd busy7", 64'(busy[7]), 64'(!FWD));
    step();
    checkOutput("fwd busy7 after", 64'(busy[7]), 64'd0);

    // Asynchronous reset while fma is granted and a write is on the port.
    issue_valid = 1'b1; issue_rd = 5'd3;
    ld_valid = 1'b1; ld_addr = 5'd4;
    step();
    issue_valid = 1'b0; ld_valid = 1'b0;
    fma_valid = 1'b1; fma_addr = 5'd20; fma_data = 64'h77;
    #1;
    checkOutput("rst pre ready", 64'(readies()), 64'b010);
    checkOutput("rst pre rf_we", 64'(rf_we), 64'd1);
    checkOutput("rst pre busy", 64'(busy), 64'h1000 | 64'h8);
    reset = 1'b1;
    #1;
    checkOutput("rst async rf_we", 64'(rf_we), 64'd0);
    checkOutput("rst async rf_wa", 64'(rf_wa), 64'd0);
    checkOutput("rst async busy", 64'(busy), 64'd0);
    step();
    fma_valid = 1'b0;
    #1;
    reset = 1'b0;
    step();
    checkOutput("rst post rf_we", 64'(rf_we), 64'd0);
    checkOutput("rst post rf_wa", 64'(rf_wa), 64'd0);
    checkOutput("rst post busy", 64'(busy), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
